// File: rtl/regfile_dual_read.sv
// 32-entry register file with one write port and a two-port read served via a
// valid/ready request/response handshake; entry 0 reads as zero.
module regfile_dual_read #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b
);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] data_a_q, data_a_d;
  logic [WIDTH-1:0] data_b_q, data_b_d;
  logic             wr_ok_s;
  logic             accept_s;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return (addr != {ADDR_W{1'b0}}) && ({1'b0, addr} < DEPTH_L);
  endfunction

  // Zero for unmapped addresses, otherwise forward a same-edge write over the stored value.
  function automatic logic [WIDTH-1:0] read_sel(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] val;
    if (!addr_ok(addr)) begin
      val = {WIDTH{1'b0}};
    end else if (wr_ok_s && (wr_addr == addr)) begin
      val = wr_data;
    end else begin
      val = mem_q[addr];
    end
    return val;
  endfunction

  assign wr_ok_s       = wr_en && addr_ok(wr_addr);
  assign rd_req_ready  = (state_q == IDLE) || rd_resp_ready;
  assign accept_s      = rd_req_valid && rd_req_ready;
  assign rd_resp_valid = (state_q == HOLD);
  assign rd_data_a     = data_a_q;
  assign rd_data_b     = data_b_q;

  always_comb begin
    state_d  = state_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (rd_resp_ready) begin
          state_d = accept_s ? HOLD : IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept_s) begin
      data_a_d = read_sel(rd_addr_a);
      data_b_d = read_sel(rd_addr_b);
    end else begin
      data_a_d = data_a_q;
      data_b_d = data_b_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      data_a_q <= {WIDTH{1'b0}};
      data_b_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_ok_s) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_regfile_dual_read.sv
// Directed bench for regfile_dual_read: a reference model predicts each response
// at the accepting edge and a scoreboard queue compares it when it is presented.
module tb_regfile_dual_read;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        rd_resp_valid;
  logic        rd_resp_ready;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;

  int          checks;
  int          errors;
  int          resp_seen;
  logic [31:0] model_mem [32];
  logic        model_hold;
  exp_t        sb_q [$];
  exp_t        e;

  regfile_dual_read #(.WIDTH(32), .ADDR_W(5), .DEPTH(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_ready(rd_resp_ready),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
    if (wr_en && (wr_addr == addr)) return wr_data;
    return model_mem[addr];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    model_hold = 1'b0;
    sb_q.delete();
  endtask

  // Sample at the falling edge, update the model for the coming rising edge, then
  // move inputs 2ns after that rising edge.
  task automatic step();
    logic acc;
    @(negedge clk);
    chk("resp_valid", {31'd0, rd_resp_valid}, {31'd0, model_hold});
    chk("req_ready", {31'd0, rd_req_ready}, {31'd0, (!model_hold || rd_resp_ready)});
    if (model_hold) begin
      if (sb_q.size() == 0) begin
        chk("sb_nonempty", 32'd0, 32'd1);
      end else begin
        chk("data_a", rd_data_a, sb_q[0].a);
        chk("data_b", rd_data_b, sb_q[0].b);
        if (rd_resp_ready) begin
          void'(sb_q.pop_front());
          resp_seen++;
        end
      end
    end
    acc = rd_req_valid && (!model_hold || rd_resp_ready);
    if (acc) begin
      e.a = model_read(rd_addr_a);
      e.b = model_read(rd_addr_b);
      sb_q.push_back(e);
      model_hold = 1'b1;
    end else if (rd_resp_ready) begin
      model_hold = 1'b0;
    end
    if (wr_en && wr_addr != 5'd0) model_mem[wr_addr] = wr_data;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    rd_req_valid = 1'b0; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    rd_resp_ready = 1'b1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
  endtask

  task automatic req(input logic [4:0] a, input logic [4:0] b);
    rd_req_valid = 1'b1; rd_addr_a = a; rd_addr_b = b;
  endtask

  initial begin
    checks = 0; errors = 0; resp_seen = 0;
    e = '0;
    idle_inputs();
    model_clear();
    reset_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, rd_resp_valid}, 32'd0);
    chk("rst_data_a", rd_data_a, 32'h0);
    chk("rst_data_b", rd_data_b, 32'h0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    step();

    // Reset contents: entries 3 and 7 read zero.
    req(5'd3, 5'd7); step();
    idle_inputs(); step();

    // Basic write then read.
    wr(5'd5, 32'h00FF_FAAA); step();
    idle_inputs(); req(5'd5, 5'd0); step();
    idle_inputs(); step();
    chk("basic_a", rd_data_a, 32'h00FF_FAAA);

    // Writes to entry 0 are dropped; wr_en=0 leaves entry 9 alone.
    wr(5'd0, 32'hDEAD_BEEF); step();
    idle_inputs(); wr_addr = 5'd9; wr_data = 32'h00FF_F000; step();
    idle_inputs(); req(5'd0, 5'd9); step();
    idle_inputs(); step();
    chk("zero_a", rd_data_a, 32'h0);
    chk("nowr_b", rd_data_b, 32'h0);

    // Same-edge write forwarding onto both ports.
    wr(5'd10, 32'h1234_5678); req(5'd10, 5'd10); step();
    idle_inputs(); step();
    chk("fwd_a", rd_data_a, 32'h1234_5678);
    chk("fwd_b", rd_data_b, 32'h1234_5678);

    // Backpressure: held snapshot survives a later write to the same entry.
    wr(5'd4, 32'h11); step();
    idle_inputs(); rd_resp_ready = 1'b0; req(5'd4, 5'd4); step();
    idle_inputs(); rd_resp_ready = 1'b0; wr(5'd4, 32'h22);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_req_ready", {31'd0, rd_req_ready}, 32'd0);
      chk("bp_hold_a", rd_data_a, 32'h11);
    end
    idle_inputs(); step();
    req(5'd4, 5'd0); step();
    idle_inputs(); step();
    chk("bp_after_a", rd_data_a, 32'h22);

    // Throughput: three back-to-back reads with no bubbles.
    wr(5'd1, 32'hA1); step();
    wr(5'd2, 32'hB2); step();
    wr(5'd3, 32'hC3); step();
    idle_inputs(); step();
    resp_seen = 0;
    req(5'd1, 5'd2); step();
    req(5'd2, 5'd3); step();
    req(5'd3, 5'd1); step();
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
    chk("tput_count", resp_seen, 32'd3);

    // Reset while a response is pending drops it immediately.
    rd_resp_ready = 1'b0; req(5'd2, 5'd3); step();
    idle_inputs(); rd_resp_ready = 1'b0;
    chk("pre_rst_a", rd_data_a, 32'hB2);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, rd_resp_valid}, 32'd0);
    chk("mid_rst_a", rd_data_a, 32'h0);
    chk("mid_rst_b", rd_data_b, 32'h0);
    model_clear();
    @(posedge clk); #2;
    reset_n = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
    req(5'd2, 5'd3); step();
    idle_inputs(); step();
    chk("post_rst_a", rd_data_a, 32'h0);
    step();

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dual_read.md
Name: regfile_dual_read

Overview:
- 32-entry general-purpose register file for the CPU datapath: one write port, two read ports served through a valid/ready request/response handshake.
- Entry 0 is hardwired to zero.
- Reads return a registered snapshot one cycle after acceptance, with same-cycle write forwarding.
- Sits between the decode stage, which issues rs/rt read requests, and the writeback stage, which drives the write port.

Parameters:
- WIDTH, 32: data width of each entry.
- ADDR_W, 5: address width of each port.
- DEPTH, 32: number of entries. Must satisfy 2 <= DEPTH <= 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  block can accept a read request.
- rd_addr_a  in  ADDR_W  read address, port A.
- rd_addr_b  in  ADDR_W  read address, port B.
- rd_resp_valid  out  1  response data valid.
- rd_resp_ready  in  1  consumer accepts the response.
- rd_data_a  out  WIDTH  port A data.
- rd_data_b  out  WIDTH  port B data.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately and independent of clk):
  - all entries = 0
  - rd_resp_valid = 0
  - rd_data_a = rd_data_b = 0
  - response stage = IDLE
- Reset asserted mid-response drops the pending response. No response is produced after reset deasserts until a new request is accepted.
- Write:
  - On a rising edge with wr_en=1, wr_addr!=0 and wr_addr<DEPTH: entry[wr_addr] <= wr_data.
  - Writes to address 0 or to addresses >= DEPTH are ignored.
  - Writes are independent of the read handshake and are never stalled.
- Read accept:
  - rd_req_ready = (state==IDLE) || rd_resp_ready. This is combinational, with no dependency on rd_req_valid.
  - A request is accepted on a rising edge where rd_req_valid && rd_req_ready.
- Response latency: exactly 1 cycle. On the accepting edge rd_data_a/b are loaded and rd_resp_valid <= 1.
- Read data selection, per port, for address X:
  - X==0 or X>=DEPTH: 0.
  - Else if wr_en && wr_addr==X on the same edge: wr_data (write forwarding).
  - Else: entry[X].
- Snapshot rule: once loaded, rd_data_a/b hold stable while rd_resp_valid && !rd_resp_ready. Later writes to the same address do not change the held response.
- Response stage FSM:
  - IDLE: rd_resp_valid=0. Accept leads to HOLD.
  - HOLD: rd_resp_valid=1.
    - rd_resp_ready=1 with a new accept: stay in HOLD and load new data (back-to-back, full throughput).
    - rd_resp_ready=1 with no accept: go to IDLE. Data registers keep their last value.
    - rd_resp_ready=0: stay in HOLD, outputs frozen, rd_req_ready=0.
- rd_addr_a == rd_addr_b is legal; both ports return identical data.
- rd_req_valid may drop without acceptance; there is no obligation to hold a request.

Test Plan:
- Reset: drive reset_n=0 mid-cycle -> outputs 0 immediately. After release, request addr_a=3, addr_b=7 -> one cycle later rd_resp_valid=1, both data 0.
- Basic write/read: write 0x00FFFAAA to entry 5 (wr_en=1), next cycle request a=5, b=0 -> response a=0x00FFFAAA, b=0.
- Zero register: write 0xDEADBEEF to address 0, then read a=0 -> 0x00000000. Also wr_en=0 with wr_addr=9, wr_data=0x00FFF000 -> entry 9 unchanged on readback.
- Forwarding: same edge writes 0x12345678 to entry 10 and accepts a read of a=10, b=10 -> both ports 0x12345678.
- Backpressure snapshot: accept a read of entry 4 (=0x11), hold rd_resp_ready=0 for 3 cycles while writing 0x22 to entry 4 -> rd_req_ready=0, data stays 0x11. Raise ready -> transfer completes, next read returns 0x22.
- Throughput: rd_req_valid=1 and rd_resp_ready=1 for reads of entries 1,2,3 on consecutive cycles -> 3 responses in 3 consecutive cycles, in order, no bubbles.
